// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU-op codes,
// control-bundle layout and the bubble constant.
package ctrl_pkg;

  // RV32I base opcodes accepted by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] ALU_OP_IMM    = 3'b010;
  localparam logic [2:0] ALU_OP_REG    = 3'b011;
  localparam logic [2:0] ALU_OP_MULDIV = 3'b100;

  // Bundle field LSB offsets; the listed fields add up to 20 bits
  localparam int unsigned F_VALID     = 0;
  localparam int unsigned F_ALU_OP    = 1;
  localparam int unsigned F_ALU_1_SRC = 4;
  localparam int unsigned F_ALU_2_SRC = 6;
  localparam int unsigned F_REG_WRITE = 7;
  localparam int unsigned F_IS_BRANCH = 8;
  localparam int unsigned F_IS_JALR   = 9;
  localparam int unsigned F_IS_JAL    = 10;
  localparam int unsigned F_MEM_READ  = 11;
  localparam int unsigned F_MEM_WRITE = 12;
  localparam int unsigned F_MEM_WIDTH = 13;
  localparam int unsigned F_MEM_SEXT  = 15;
  localparam int unsigned F_REG_SRC   = 16;
  localparam int unsigned F_IS_MULDIV = 18;
  localparam int unsigned F_ILLEGAL   = 19;
  localparam int unsigned CTRL_W      = 20;

  // Packed view of the bundle, MSB first so bit positions match the offsets
  typedef struct packed {
    logic       illegal;
    logic       is_muldiv;
    logic [1:0] reg_src;
    logic       mem_sign_extend;
    logic [1:0] mem_width;
    logic       mem_write;
    logic       mem_read;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       reg_write;
    logic       alu_2_src;
    logic [1:0] alu_1_src;
    logic [2:0] alu_op;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decoder: instruction fields to control bundle plus
// register-operand use flags for hazard detection.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2
);

  logic legal;

  // Opcode whitelist decode; anything unrecognised becomes a valid illegal bundle
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    unique case (opcode)
      OPC_LUI: begin
        ctrl.alu_1_src = 2'b01;
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_1_src = 2'b10;
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jal    = 1'b1;
        ctrl.reg_src   = 2'b10;
      end
      OPC_JALR: begin
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.is_jalr   = 1'b1;
        ctrl.reg_src   = 2'b10;
        use_rs1        = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_src   = 2'b01;
        use_rs1        = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_2_src = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_op    = ALU_OP_IMM;
        ctrl.alu_2_src = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
          if (EN_MEXT) begin
            ctrl.alu_op    = ALU_OP_MULDIV;
            ctrl.is_muldiv = 1'b1;
            ctrl.reg_write = 1'b1;
          end else begin
            legal = 1'b0;
          end
        end else begin
          ctrl.alu_op    = ALU_OP_REG;
          ctrl.reg_write = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase

    if (legal) begin
      ctrl.valid           = 1'b1;
      ctrl.mem_width       = funct3[1:0];
      ctrl.mem_sign_extend = ~funct3[2];
    end else begin
      ctrl         = CTRL_BUBBLE;
      ctrl.valid   = 1'b1;
      ctrl.illegal = 1'b1;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in ID, carries bundles through ID/EX,
// EX/MEM and MEM/WB, and handles load-use stalls, flushes and MUL/DIV occupancy.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit          EN_MEXT      = 1'b1,
  parameter int unsigned MDIV_LATENCY = 4,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_busy_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [REG_AW-1:0] mem_rd_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic [REG_AW-1:0] wb_rd_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDIV_LATENCY - 1);

  ctrl_t             dec_ctrl;
  logic              use_rs1;
  logic              use_rs2;
  logic              load_use;
  logic              busy;

  ctrl_t             ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [CNT_W-1:0]  mdiv_cnt;

  ctrl_t             next_ex_ctrl, next_mem_ctrl, next_wb_ctrl;
  logic [REG_AW-1:0] next_ex_rd, next_mem_rd, next_wb_rd;
  logic [CNT_W-1:0]  next_mdiv_cnt;

  ctrl_decode #(
    .EN_MEXT (EN_MEXT)
  ) u_decode (
    .opcode  (opcode_i),
    .funct3  (funct3_i),
    .funct7  (funct7_i),
    .ctrl    (dec_ctrl),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  // Hazard detection: EX holds a load whose nonzero rd feeds an operand used in ID
  always_comb begin
    busy     = (mdiv_cnt != '0);
    load_use = valid_i & ex_ctrl.valid & ex_ctrl.mem_read & (ex_rd != '0) &
               ((use_rs1 & (rs1_i == ex_rd)) | (use_rs2 & (rs2_i == ex_rd)));
  end

  // Next-state selection by priority: busy, flush, load-use, normal advance
  always_comb begin
    next_wb_ctrl  = mem_ctrl;
    next_wb_rd    = mem_rd;
    next_mem_ctrl = ex_ctrl;
    next_mem_rd   = ex_rd;
    next_ex_ctrl  = CTRL_BUBBLE;
    next_ex_rd    = '0;
    next_mdiv_cnt = busy ? (mdiv_cnt - CNT_W'(1)) : '0;
    if (busy) begin
      // MUL/DIV keeps EX; a flush cannot apply until it leaves
      next_ex_ctrl  = ex_ctrl;
      next_ex_rd    = ex_rd;
      next_mem_ctrl = CTRL_BUBBLE;
      next_mem_rd   = '0;
    end else if (flush_i || load_use) begin
      next_ex_ctrl = CTRL_BUBBLE;
      next_ex_rd   = '0;
    end else if (valid_i) begin
      next_ex_ctrl = dec_ctrl;
      next_ex_rd   = rd_i;
      if (dec_ctrl.is_muldiv) begin
        next_mdiv_cnt = CNT_LOAD;
      end
    end
  end

  // Stage registers and MUL/DIV counter with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl  <= CTRL_BUBBLE;
      mem_ctrl <= CTRL_BUBBLE;
      wb_ctrl  <= CTRL_BUBBLE;
      ex_rd    <= '0;
      mem_rd   <= '0;
      wb_rd    <= '0;
      mdiv_cnt <= '0;
    end else begin
      ex_ctrl  <= next_ex_ctrl;
      mem_ctrl <= next_mem_ctrl;
      wb_ctrl  <= next_wb_ctrl;
      ex_rd    <= next_ex_rd;
      mem_rd   <= next_mem_rd;
      wb_rd    <= next_wb_rd;
      mdiv_cnt <= next_mdiv_cnt;
    end
  end

  assign stall_o    = busy | load_use;
  assign ex_busy_o  = busy;
  assign ex_ctrl_o  = ex_ctrl;
  assign mem_ctrl_o = mem_ctrl;
  assign wb_ctrl_o  = wb_ctrl;
  assign ex_rd_o    = ex_rd;
  assign mem_rd_o   = mem_rd;
  assign wb_rd_o    = wb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: decode vector table plus directed
// sequences for reset, load-use, flush, MUL/DIV occupancy and reset-while-busy.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  typedef logic [CTRL_W-1:0] cw_t;

  typedef struct {
    logic       vld;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rdx;
    cw_t        exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, valid, flush;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  logic       stall, busy, nm_stall, nm_busy, l1_stall, l1_busy;
  cw_t        ex_ctrl, mem_ctrl, wb_ctrl, nm_ex, nm_mem, nm_wb, l1_ex, l1_mem, l1_wb;
  logic [4:0] ex_rd, mem_rd, wb_rd, nm_exrd, nm_memrd, nm_wbrd, l1_exrd, l1_memrd, l1_wbrd;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.EN_MEXT(1'b1), .MDIV_LATENCY(4), .REG_AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
    .stall_o(stall), .ex_busy_o(busy), .ex_ctrl_o(ex_ctrl), .ex_rd_o(ex_rd),
    .mem_ctrl_o(mem_ctrl), .mem_rd_o(mem_rd), .wb_ctrl_o(wb_ctrl), .wb_rd_o(wb_rd)
  );

  ctrl_pipe #(.EN_MEXT(1'b0), .MDIV_LATENCY(4), .REG_AW(5)) dut_nm (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
    .stall_o(nm_stall), .ex_busy_o(nm_busy), .ex_ctrl_o(nm_ex), .ex_rd_o(nm_exrd),
    .mem_ctrl_o(nm_mem), .mem_rd_o(nm_memrd), .wb_ctrl_o(nm_wb), .wb_rd_o(nm_wbrd)
  );

  ctrl_pipe #(.EN_MEXT(1'b1), .MDIV_LATENCY(1), .REG_AW(5)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .opcode_i(opcode), .funct3_i(funct3),
    .funct7_i(funct7), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .flush_i(flush),
    .stall_o(l1_stall), .ex_busy_o(l1_busy), .ex_ctrl_o(l1_ex), .ex_rd_o(l1_exrd),
    .mem_ctrl_o(l1_mem), .mem_rd_o(l1_memrd), .wb_ctrl_o(l1_wb), .wb_rd_o(l1_wbrd)
  );

  // Packs hand-chosen field values of a legal instruction into a bundle
  function automatic cw_t mk(input logic [2:0] alu, input logic [1:0] a1, input logic a2,
                             input logic rw, input logic br, input logic jr, input logic jl,
                             input logic mr, input logic mw, input logic [1:0] w,
                             input logic sx, input logic [1:0] rsrc, input logic md);
    cw_t c;
    c = '0;
    c[F_VALID]          = 1'b1;
    c[F_ALU_OP +: 3]    = alu;
    c[F_ALU_1_SRC +: 2] = a1;
    c[F_ALU_2_SRC]      = a2;
    c[F_REG_WRITE]      = rw;
    c[F_IS_BRANCH]      = br;
    c[F_IS_JALR]        = jr;
    c[F_IS_JAL]         = jl;
    c[F_MEM_READ]       = mr;
    c[F_MEM_WRITE]      = mw;
    c[F_MEM_WIDTH +: 2] = w;
    c[F_MEM_SEXT]       = sx;
    c[F_REG_SRC +: 2]   = rsrc;
    c[F_IS_MULDIV]      = md;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdn);
    valid = v; opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = rdn;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[15];
  cw_t  e_addi, e_add, e_lw, e_beq, e_mul, e_ill;

  initial begin
    e_addi = mk(3'b010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    e_add  = mk(3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    e_lw   = mk(3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b01, 1'b0);
    e_beq  = mk(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    e_mul  = mk(3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1);
    e_ill  = '0;
    e_ill[F_VALID]   = 1'b1;
    e_ill[F_ILLEGAL] = 1'b1;

    tbl[0]  = '{1'b1, 7'b0010011, 3'b000, 7'b0000000, 5'd7, e_addi};
    tbl[1]  = '{1'b1, 7'b0110011, 3'b000, 7'b0000000, 5'd8, e_add};
    tbl[2]  = '{1'b1, 7'b0110011, 3'b101, 7'b0100000, 5'd9,
                mk(3'b011, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0)};
    tbl[3]  = '{1'b1, 7'b0110111, 3'b011, 7'b0000000, 5'd10,
                mk(3'b000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0)};
    tbl[4]  = '{1'b1, 7'b0010111, 3'b000, 7'b0000000, 5'd11,
                mk(3'b000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0)};
    tbl[5]  = '{1'b1, 7'b1101111, 3'b000, 7'b0000000, 5'd1,
                mk(3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0)};
    tbl[6]  = '{1'b1, 7'b1100111, 3'b000, 7'b0000000, 5'd0,
                mk(3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0)};
    tbl[7]  = '{1'b1, 7'b1100011, 3'b001, 7'b0000000, 5'd12,
                mk(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0)};
    tbl[8]  = '{1'b1, 7'b0000011, 3'b010, 7'b0000000, 5'd13, e_lw};
    tbl[9]  = '{1'b1, 7'b0000011, 3'b100, 7'b0000000, 5'd14,
                mk(3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0)};
    tbl[10] = '{1'b1, 7'b0100011, 3'b010, 7'b0000000, 5'd15,
                mk(3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0)};
    tbl[11] = '{1'b1, 7'b1110011, 3'b000, 7'b0000000, 5'd16, e_ill};
    tbl[12] = '{1'b1, 7'b0000000, 3'b000, 7'b0000000, 5'd17, e_ill};
    tbl[13] = '{1'b1, 7'b0001111, 3'b000, 7'b0000000, 5'd18, e_ill};
    tbl[14] = '{1'b0, 7'b0010011, 3'b000, 7'b0000000, 5'd19, '0};

    // Reset held two cycles with a valid ADDI in ID
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd7);
    tick; tick;
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    chk("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick;
    chk("rst_release_addi", 32'(ex_ctrl), 32'(e_addi));
    chk("rst_release_rd", 32'(ex_rd), 32'd7);
    valid = 1'b0;
    tick;

    // Decode table: each instruction followed by an idle cycle
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].f3, tbl[i].f7, 5'd1, 5'd2, tbl[i].rdx);
      tick;
      chk($sformatf("decode[%0d].ctrl", i), 32'(ex_ctrl), 32'(tbl[i].exp));
      chk($sformatf("decode[%0d].rd", i), 32'(ex_rd), tbl[i].vld ? 32'(tbl[i].rdx) : 32'd0);
      valid = 1'b0;
      tick;
    end

    // Load-use: LW x5 then ADD x6,x5,x1
    drive(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd2, 5'd0, 5'd5);
    tick;
    chk("lu_lw_ctrl", 32'(ex_ctrl), 32'(e_lw));
    drive(1'b1, 7'b0110011, 3'b000, 7'd0, 5'd5, 5'd1, 5'd6);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick;
    chk("lu_bubble", 32'(ex_ctrl), 32'd0);
    chk("lu_mem_lw", 32'(mem_ctrl), 32'(e_lw));
    chk("lu_stall_once", 32'(stall), 32'd0);
    tick;
    chk("lu_add_ex", 32'(ex_ctrl), 32'(e_add));
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_mem_bubble", 32'(mem_ctrl), 32'd0);
    chk("lu_wb_lw", 32'(wb_ctrl), 32'(e_lw));

    // LW x0 never stalls
    drive(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd2, 5'd0, 5'd0);
    tick;
    drive(1'b1, 7'b0110011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd6);
    #1;
    chk("lu_x0_no_stall", 32'(stall), 32'd0);
    tick;
    chk("lu_x0_add", 32'(ex_ctrl), 32'(e_add));

    // Operand-use gating: LUI ignores rs1, STORE uses rs2
    drive(1'b1, 7'b0000011, 3'b010, 7'd0, 5'd2, 5'd0, 5'd9);
    tick;
    drive(1'b1, 7'b0110111, 3'b000, 7'd0, 5'd9, 5'd9, 5'd4);
    #1;
    chk("lu_lui_no_stall", 32'(stall), 32'd0);
    drive(1'b1, 7'b0100011, 3'b010, 7'd0, 5'd3, 5'd9, 5'd0);
    #1;
    chk("lu_store_rs2", 32'(stall), 32'd1);
    tick;
    valid = 1'b0;
    tick;

    // Flush with BEQ in EX and ADDI in ID
    drive(1'b1, 7'b1100011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0);
    tick;
    chk("fl_beq_ex", 32'(ex_ctrl), 32'(e_beq));
    drive(1'b1, 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd7);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_ex_bubble", 32'(ex_ctrl), 32'd0);
    chk("fl_ex_rd", 32'(ex_rd), 32'd0);
    chk("fl_mem_beq", 32'(mem_ctrl), 32'(e_beq));
    tick;
    chk("fl_addi_after", 32'(ex_ctrl), 32'(e_addi));
    valid = 1'b0;
    tick;

    // MUL x3 with latency 4, flush asserted during busy
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd3);
    tick;
    chk("md_ex_mul", 32'(ex_ctrl), 32'(e_mul));
    chk("md_busy0", 32'(busy), 32'd1);
    chk("md_stall0", 32'(stall), 32'd1);
    chk("md_nomext_ill", 32'(nm_ex), 32'(e_ill));
    chk("md_nomext_busy", 32'(nm_busy), 32'd0);
    chk("md_lat1_ex", 32'(l1_ex), 32'(e_mul));
    chk("md_lat1_busy", 32'(l1_busy), 32'd0);
    drive(1'b1, 7'b0010011, 3'b000, 7'd0, 5'd3, 5'd0, 5'd4);
    flush = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      chk($sformatf("md_hold[%0d]", c), 32'(ex_ctrl), 32'(e_mul));
      chk($sformatf("md_mem_bubble[%0d]", c), 32'(mem_ctrl), 32'd0);
      chk($sformatf("md_busy[%0d]", c), 32'(busy), (c < 3) ? 32'd1 : 32'd0);
    end
    flush = 1'b0;
    tick;
    chk("md_addi_ex", 32'(ex_ctrl), 32'(e_addi));
    chk("md_addi_rd", 32'(ex_rd), 32'd4);
    chk("md_mem_mul", 32'(mem_ctrl), 32'(e_mul));

    // Reset while busy
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd3);
    tick;
    chk("rb_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    valid = 1'b0;
    tick;
    chk("rb_busy", 32'(busy), 32'd0);
    chk("rb_stall", 32'(stall), 32'd0);
    chk("rb_ex", 32'(ex_ctrl), 32'd0);
    chk("rb_mem", 32'(mem_ctrl), 32'd0);
    chk("rb_wb", 32'(wb_ctrl), 32'd0);
    rst = 1'b0;
    tick;
    chk("rb_no_residual", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
